// File: rtl/dmem_responder.sv
// Word-addressed data RAM for the cpu data bus: programmable read latency,
// ready handshake, and fault reporting for misaligned / out-of-window accesses.
module dmem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          READ_LAT  = 2,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        CS,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic        ready,
    output logic        rd_valid,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int unsigned LAT   = (READ_LAT < 1) ? 32'd1 :
                                    (READ_LAT > 4) ? 32'd4 : 32'(READ_LAT);
    localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
    localparam logic [2:0]  LAT_CNT = 3'(LAT);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    logic [31:0]          mem [DEPTH];
    logic [31:0]          off;
    logic [ADDR_BITS-1:0] idx;
    logic                 fault;
    logic                 accept;

    state_t               state;
    logic [2:0]           cnt;
    logic                 pend;
    logic                 cap_fault;
    logic [ADDR_BITS-1:0] cap_idx;
    logic [31:0]          cap_addr;

    // Address decode; a wrap in ADDR - BASE_ADDR is caught by the ADDR < BASE_ADDR term.
    always_comb begin
        off    = ADDR - BASE_ADDR;
        idx    = off[ADDR_BITS+1:2];
        fault  = (ADDR[1:0] != 2'b00) || (ADDR < BASE_ADDR) || ({1'b0, off} >= SPAN);
        accept = CS && ready;
    end

    // RAM array is deliberately never cleared by reset.
    always_ff @(posedge CLK) begin
        if (!reset && accept && WE && !fault) begin
            mem[idx] <= Data_BUS_WRITE;
        end
    end

    // Read sequencing: cnt counts edges left until the completion edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            pend          <= 1'b0;
            cap_fault     <= 1'b0;
            cap_idx       <= '0;
            cap_addr      <= 32'd0;
            Data_BUS_READ <= 32'd0;
            ready         <= 1'b1;
            rd_valid      <= 1'b0;
            err           <= 1'b0;
            err_addr      <= 32'd0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;

            if (pend && (cnt == 3'd1)) begin
                pend     <= 1'b0;
                cnt      <= 3'd0;
                state    <= IDLE;
                ready    <= 1'b1;
                rd_valid <= 1'b1;
                if (cap_fault) begin
                    Data_BUS_READ <= ERR_DATA;
                    err           <= 1'b1;
                    err_addr      <= cap_addr;
                end else begin
                    Data_BUS_READ <= mem[cap_idx];
                end
            end else if (state == RD_WAIT) begin
                cnt   <= cnt - 3'd1;
                ready <= (cnt == 3'd2);
            end

            // A new request may land on the same edge a read completes.
            if (accept) begin
                if (WE) begin
                    if (fault) begin
                        err      <= 1'b1;
                        err_addr <= ADDR;
                    end
                end else begin
                    pend      <= 1'b1;
                    cnt       <= LAT_CNT;
                    cap_fault <= fault;
                    cap_idx   <= idx;
                    cap_addr  <= ADDR;
                    state     <= (LAT > 1) ? RD_WAIT : IDLE;
                    ready     <= (LAT == 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three configurations share one request stream and
// are compared every cycle against a transaction-level model, plus directed cases.
module tb_dmem_responder;

    localparam int          ND  = 3;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rd_o  [ND];
    logic        rdy_o [ND];
    logic        rv_o  [ND];
    logic        er_o  [ND];
    logic [31:0] ea_o  [ND];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .READ_LAT(2)) u_a (
        .CLK(clk), .reset(reset), .CS(cs), .WE(we), .ADDR(addr), .Data_BUS_WRITE(wdata),
        .Data_BUS_READ(rd_o[0]), .ready(rdy_o[0]), .rd_valid(rv_o[0]), .err(er_o[0]), .err_addr(ea_o[0]));

    dmem_responder #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .READ_LAT(1)) u_b (
        .CLK(clk), .reset(reset), .CS(cs), .WE(we), .ADDR(addr), .Data_BUS_WRITE(wdata),
        .Data_BUS_READ(rd_o[1]), .ready(rdy_o[1]), .rd_valid(rv_o[1]), .err(er_o[1]), .err_addr(ea_o[1]));

    dmem_responder #(.ADDR_BITS(10), .BASE_ADDR(32'h800), .READ_LAT(7)) u_c (
        .CLK(clk), .reset(reset), .CS(cs), .WE(we), .ADDR(addr), .Data_BUS_WRITE(wdata),
        .Data_BUS_READ(rd_o[2]), .ready(rdy_o[2]), .rd_valid(rv_o[2]), .err(er_o[2]), .err_addr(ea_o[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          lat_m  [ND] = '{2, 1, 4};
    logic [31:0] base_m [ND] = '{32'h0, 32'h0, 32'h800};
    logic [31:0] mm     [ND][1024];
    bit          known  [ND][1024];
    logic [31:0] m_rd [ND];
    logic [31:0] m_ea [ND];
    logic [31:0] m_ca [ND];
    bit          m_rdk [ND];
    bit          m_rv [ND];
    bit          m_err [ND];
    bit          m_ready [ND];
    bit          m_pend [ND];
    bit          m_cf [ND];
    int          m_ci [ND];
    int          m_done [ND];
    int          cyc = 0;
    bit          model_live = 1'b0;

    function automatic void decode(input logic [31:0] a, input logic [31:0] b,
                                   output bit f, output int ix);
        logic [31:0] o;
        f  = 1'b0;
        ix = 0;
        if (a < b) begin
            f = 1'b1;
        end else begin
            o = a - b;
            if ((a % 4) != 0 || o >= 32'd4096) f = 1'b1;
            else ix = int'(o / 4);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) model_live = 1'b1;
        for (int d = 0; d < ND; d++) begin
            bit f;
            int ix;
            if (reset) begin
                m_rd[d] = 32'd0; m_rdk[d] = 1'b1; m_rv[d] = 1'b0; m_err[d] = 1'b0;
                m_ea[d] = 32'd0; m_ready[d] = 1'b1; m_pend[d] = 1'b0;
            end else begin
                m_rv[d]  = 1'b0;
                m_err[d] = 1'b0;
                if (m_pend[d] && cyc == m_done[d]) begin
                    m_pend[d] = 1'b0;
                    m_rv[d]   = 1'b1;
                    if (m_cf[d]) begin
                        m_rd[d] = ERR; m_rdk[d] = 1'b1; m_err[d] = 1'b1; m_ea[d] = m_ca[d];
                    end else begin
                        m_rd[d] = mm[d][m_ci[d]]; m_rdk[d] = known[d][m_ci[d]];
                    end
                end
                if (cs && m_ready[d]) begin
                    decode(addr, base_m[d], f, ix);
                    if (we) begin
                        if (f) begin m_err[d] = 1'b1; m_ea[d] = addr; end
                        else begin mm[d][ix] = wdata; known[d][ix] = 1'b1; end
                    end else begin
                        m_pend[d] = 1'b1; m_done[d] = cyc + lat_m[d];
                        m_cf[d] = f; m_ci[d] = ix; m_ca[d] = addr;
                    end
                end
                m_ready[d] = !m_pend[d] || (m_done[d] == cyc + 1);
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (model_live) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("u%0d_ready", d), 32'(rdy_o[d]), 32'(m_ready[d]));
                chk($sformatf("u%0d_rd_valid", d), 32'(rv_o[d]), 32'(m_rv[d]));
                chk($sformatf("u%0d_err", d), 32'(er_o[d]), 32'(m_err[d]));
                chk($sformatf("u%0d_err_addr", d), ea_o[d], m_ea[d]);
                if (m_rdk[d]) chk($sformatf("u%0d_rdata", d), rd_o[d], m_rd[d]);
            end
        end
    end

    bit          mon_en = 1'b0;
    bit          b_ready_low = 1'b0;
    logic [31:0] q_d[$];
    int          q_c[$];

    always @(negedge clk) begin
        if (mon_en && rv_o[0] === 1'b1) begin
            q_d.push_back(rd_o[0]);
            q_c.push_back(cyc);
        end
        if (model_live && rdy_o[1] === 1'b0) b_ready_low = 1'b1;
    end

    task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
        cs = c; we = w; addr = a; wdata = d;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned s;
        s = $urandom_range(0, 9);
        case (s)
            0, 1, 2, 3: return 32'($urandom_range(0, 15)) << 2;
            4, 5:       return 32'h800 + (32'($urandom_range(0, 15)) << 2);
            6:          return 32'hFFC;
            7:          return 32'h17FC;
            8:          return 32'($urandom_range(0, 63));
            default:    return ($urandom_range(0, 1) == 1) ? 32'h1800 : 32'hFFFF_FFFC;
        endcase
    endfunction

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0BAD_F00D};
        tbl[2]  = '{1'b1, 32'h0000_1000, 32'h5555_5555, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, ERR};
        tbl[4]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, ERR};
        tbl[5]  = '{1'b1, 32'h0000_0003, 32'h7777_7777, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1};
        tbl[7]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h2};
        tbl[8]  = '{1'b1, 32'h0000_0008, 32'h3333_0000, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h3333_0000};
        tbl[10] = '{1'b0, 32'h0000_0002, 32'h0,         1'b1, ERR};
        tbl[11] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_22B4};

        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_rdata", rd_o[0], 32'h0);
        chk("rst_rd_valid", 32'(rv_o[0]), 32'h0);
        chk("rst_err", 32'(er_o[0]), 32'h0);
        chk("rst_err_addr", ea_o[0], 32'h0);
        chk("rst_ready", 32'(rdy_o[0]), 32'h1);
        reset = 1'b0;

        // write then read 0x10
        drive(1'b1, 1'b1, 32'h10, 32'h22B4); @(negedge clk);
        chk("wr_err", 32'(er_o[0]), 32'h0);
        chk("wr_ready", 32'(rdy_o[0]), 32'h1);
        drive(1'b1, 1'b0, 32'h10, 32'h0); @(negedge clk);
        chk("rd_ready_low", 32'(rdy_o[0]), 32'h0);
        chk("rd_rv_k", 32'(rv_o[0]), 32'h0);
        chk("l1_rv_k", 32'(rv_o[1]), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0); @(negedge clk);
        chk("rd_ready_back", 32'(rdy_o[0]), 32'h1);
        chk("rd_rv_k1", 32'(rv_o[0]), 32'h0);
        chk("l1_rv_k1", 32'(rv_o[1]), 32'h1);
        chk("l1_rdata_k1", rd_o[1], 32'h22B4);
        @(negedge clk);
        chk("rd_rv_k2", 32'(rv_o[0]), 32'h1);
        chk("rd_rdata_k2", rd_o[0], 32'h22B4);
        chk("rd_err_k2", 32'(er_o[0]), 32'h0);
        chk("l1_rv_k2", 32'(rv_o[1]), 32'h0);

        // back-to-back reads with CS held
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'(4 * i), 32'(i + 1)); @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n;
            n = 0;
            drive(1'b1, 1'b0, 32'(4 * i), 32'h0);
            while (rdy_o[0] !== 1'b1 && n < 8) begin
                @(negedge clk);
                n++;
            end
            if (n >= 8) chk("b2b_ready_timeout", 32'(rdy_o[0]), 32'h1);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        chk("b2b_count", 32'(q_d.size()), 32'd3);
        for (int i = 0; i < q_d.size() && i < 3; i++) chk($sformatf("b2b_data%0d", i), q_d[i], 32'(i + 1));
        for (int i = 1; i < q_c.size(); i++) chk($sformatf("b2b_gap%0d", i), 32'(q_c[i] - q_c[i-1]), 32'd2);

        // misaligned read, out-of-range write
        drive(1'b1, 1'b0, 32'h6, 32'h0); @(negedge clk);
        chk("mis_err_k", 32'(er_o[0]), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0); @(negedge clk);
        chk("mis_rv_k1", 32'(rv_o[0]), 32'h0);
        @(negedge clk);
        chk("mis_rdata", rd_o[0], ERR);
        chk("mis_rv", 32'(rv_o[0]), 32'h1);
        chk("mis_err", 32'(er_o[0]), 32'h1);
        chk("mis_err_addr", ea_o[0], 32'h6);
        @(negedge clk);
        chk("mis_err_clear", 32'(er_o[0]), 32'h0);
        drive(1'b1, 1'b1, 32'h1000, 32'h1234_5678); @(negedge clk);
        chk("oob_err", 32'(er_o[0]), 32'h1);
        chk("oob_err_addr", ea_o[0], 32'h1000);
        drive(1'b0, 1'b0, 32'h0, 32'h0); @(negedge clk);
        chk("oob_err_pulse", 32'(er_o[0]), 32'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0); @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0); @(negedge clk); @(negedge clk);
        chk("oob_word0", rd_o[0], 32'h1);
        chk("oob_word0_rv", 32'(rv_o[0]), 32'h1);

        // latency-1 instance: write then immediate read
        drive(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5); @(negedge clk);
        drive(1'b1, 1'b0, 32'h20, 32'h0); @(negedge clk);
        chk("lat1_rv_k", 32'(rv_o[1]), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0); @(negedge clk);
        chk("lat1_rv", 32'(rv_o[1]), 32'h1);
        chk("lat1_rdata", rd_o[1], 32'hA5A5_A5A5);
        chk("lat1_ready", 32'(rdy_o[1]), 32'h1);

        // reset while a read is outstanding
        repeat (6) @(negedge clk);
        drive(1'b1, 1'b0, 32'h10, 32'h0); @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1; @(negedge clk);
        chk("rr_rv", 32'(rv_o[0]), 32'h0);
        chk("rr_err", 32'(er_o[0]), 32'h0);
        chk("rr_rdata", rd_o[0], 32'h0);
        chk("rr_ready", 32'(rdy_o[0]), 32'h1);
        reset = 1'b0; @(negedge clk);
        chk("rr_rv_after", 32'(rv_o[0]), 32'h0);
        chk("rr_err_after", 32'(er_o[0]), 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0); @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0); @(negedge clk); @(negedge clk);
        chk("rr_preserved", rd_o[0], 32'h22B4);
        chk("rr_preserved_rv", 32'(rv_o[0]), 32'h1);

        // table of single transactions on the latency-2 instance
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata); @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_werr", i), 32'(er_o[0]), 32'(tbl[i].exp_err));
                if (tbl[i].exp_err) chk($sformatf("tbl%0d_weaddr", i), ea_o[0], tbl[i].addr);
            end else begin
                @(negedge clk); @(negedge clk);
                chk($sformatf("tbl%0d_rv", i), 32'(rv_o[0]), 32'h1);
                chk($sformatf("tbl%0d_rdata", i), rd_o[0], tbl[i].exp_rd);
                chk($sformatf("tbl%0d_rerr", i), 32'(er_o[0]), 32'(tbl[i].exp_err));
                if (tbl[i].exp_err) chk($sformatf("tbl%0d_readdr", i), ea_o[0], tbl[i].addr);
            end
            @(negedge clk);
        end

        // randomized traffic, checked by the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(negedge clk);
        chk("lat1_ready_const", 32'(b_ready_low), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
